// File: rtl/su_accum_writeback.sv
`timescale 1ns/1ps
// su_accum_writeback: reduces PE-array psums down the rows in groups and writes
// each group sum (optionally accumulated and saturated) back to the psum GBF.
module su_accum_writeback #(
    parameter int ROW                    = 16,
    parameter int COL                    = 16,
    parameter int DATA_BITWIDTH          = 16,
    parameter int PSUM_RF_ADDR_BITWIDTH  = 2,
    parameter int PSUM_DEPTH             = 4,
    parameter int PSUM_GBF_DATA_BITWIDTH = 512,
    parameter int PSUM_GBF_ADDR_BITWIDTH = 5,
    parameter int PSUM_GBF_DEPTH         = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]      psum_out,
    input  logic                                  pe_psum_finish,
    input  logic                                  conv_finish,
    input  logic [2:0]                            red_mode,
    input  logic                                  accum_en,
    input  logic                                  sat_en,
    input  logic [PSUM_GBF_ADDR_BITWIDTH-1:0]     base_addr,
    input  logic [PSUM_GBF_DATA_BITWIDTH-1:0]     psum_gbf_r_data,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]      psum_rf_addr,
    output logic [PSUM_GBF_DATA_BITWIDTH-1:0]     out_data,
    output logic                                  psum_gbf_w_en,
    output logic [PSUM_GBF_ADDR_BITWIDTH-1:0]     psum_gbf_w_addr,
    output logic                                  psum_gbf_w_num,
    output logic                                  psum_gbf_r_en,
    output logic [PSUM_GBF_ADDR_BITWIDTH-1:0]     psum_gbf_r_addr,
    output logic                                  su_add_finish,
    output logic                                  busy
);

    localparam int DW = DATA_BITWIDTH;
    localparam int LR = $clog2(ROW);
    localparam int SW = DW + LR;
    localparam int AW = PSUM_GBF_ADDR_BITWIDTH;
    localparam int RW = PSUM_RF_ADDR_BITWIDTH;
    localparam int GW = PSUM_GBF_DATA_BITWIDTH;
    localparam int MW = $clog2(LR + 1);

    localparam logic signed [SW:0] SAT_MAX = {{(SW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW:0] SAT_MIN = {{(SW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RD,
        WR,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [RW-1:0] idx;
    logic [LR-1:0] g;
    logic [MW-1:0] m_q;
    logic          accum_q;
    logic          sat_q;
    logic [AW-1:0] base_q;
    logic          pend_start;
    logic          pend_swap;
    logic          w_num_q;

    logic          start;
    logic [MW-1:0] m_in;
    logic [LR-1:0] g_last;
    logic          last_g;
    logic          last_idx;
    logic [AW-1:0] addr;

    assign start    = pe_psum_finish | pend_start;
    assign m_in     = (red_mode > 3'(LR)) ? MW'(LR) : MW'(red_mode);
    assign g_last   = LR'((ROW >> m_q) - 1);
    assign last_g   = (g == g_last);
    assign last_idx = (idx == RW'(PSUM_DEPTH - 1));
    assign addr     = AW'((int'(base_q) + int'(idx) * (ROW >> m_q) + int'(g))
                          % PSUM_GBF_DEPTH);

    // Pairwise adder tree: level k holds sums of 2^k adjacent rows.
    logic signed [SW-1:0] cand [LR+1][ROW][COL];

    for (genvar k = 0; k <= LR; k++) begin : lv
        localparam int N = ROW >> k;
        logic signed [SW-1:0] s [N][COL];
        for (genvar i = 0; i < ROW; i++) begin : rw
            for (genvar c = 0; c < COL; c++) begin : cl
                if (i >= N) begin : pad
                    assign cand[k][i][c] = '0;
                end else begin : sum
                    if (k == 0) begin : leaf
                        assign s[i][c] =
                            SW'(signed'(psum_out[(i*COL+c)*DW +: DW]));
                    end else begin : node
                        assign s[i][c] = lv[k-1].s[2*i][c]
                                       + lv[k-1].s[2*i+1][c];
                    end
                    assign cand[k][i][c] = s[i][c];
                end
            end
        end
    end

    logic signed [SW-1:0] gsum_q [ROW][COL];

    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            for (int i = 0; i < ROW; i++) begin
                for (int c = 0; c < COL; c++) begin
                    gsum_q[i][c] <= cand[m_q][i][c];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = FETCH;
            FETCH:   state_nx = RD;
            RD:      state_nx = WR;
            WR: begin
                if (!last_g) begin
                    state_nx = RD;
                end else if (!last_idx) begin
                    state_nx = FETCH;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            g          <= '0;
            m_q        <= '0;
            accum_q    <= 1'b0;
            sat_q      <= 1'b0;
            base_q     <= '0;
            pend_start <= 1'b0;
            pend_swap  <= 1'b0;
            w_num_q    <= 1'b0;
        end else begin
            if (state != IDLE && pe_psum_finish) pend_start <= 1'b1;
            if (state != IDLE && conv_finish) pend_swap <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        m_q        <= m_in;
                        accum_q    <= accum_en;
                        sat_q      <= sat_en;
                        base_q     <= base_addr;
                        idx        <= '0;
                        g          <= '0;
                        pend_start <= 1'b0;
                        // a swap requested with the start lands after the pass
                        if (conv_finish) pend_swap <= 1'b1;
                    end else if (conv_finish) begin
                        w_num_q <= ~w_num_q;
                    end
                end
                FETCH: g <= '0;
                WR: begin
                    if (!last_g) begin
                        g <= g + LR'(1);
                    end else if (!last_idx) begin
                        idx <= idx + RW'(1);
                    end
                end
                DONE: begin
                    if (pend_swap || conv_finish) w_num_q <= ~w_num_q;
                    pend_swap <= 1'b0;
                    idx       <= '0;
                end
                default: ;
            endcase
        end
    end

    logic signed [DW-1:0] rd_lane;
    logic signed [SW:0]   rd_ext;
    logic signed [SW:0]   acc;
    logic [DW-1:0]        lane;
    logic [GW-1:0]        wr_data;

    always_comb begin
        wr_data = '0;
        rd_lane = '0;
        rd_ext  = '0;
        acc     = '0;
        lane    = '0;
        for (int c = 0; c < COL; c++) begin
            rd_lane = signed'(psum_gbf_r_data[c*DW +: DW]);
            rd_ext  = accum_q ? (SW+1)'(rd_lane) : '0;
            acc     = (SW+1)'(gsum_q[g][c]) + rd_ext;
            if (sat_q && acc > SAT_MAX) begin
                lane = SAT_MAX[DW-1:0];
            end else if (sat_q && acc < SAT_MIN) begin
                lane = SAT_MIN[DW-1:0];
            end else begin
                lane = acc[DW-1:0];
            end
            wr_data[c*DW +: DW] = lane;
        end
    end

    always_comb begin
        psum_gbf_r_en   = 1'b0;
        psum_gbf_r_addr = '0;
        psum_gbf_w_en   = 1'b0;
        psum_gbf_w_addr = '0;
        out_data        = '0;
        su_add_finish   = 1'b0;
        unique case (state)
            RD: begin
                psum_gbf_r_en   = accum_q;
                psum_gbf_r_addr = addr;
            end
            WR: begin
                psum_gbf_w_en   = 1'b1;
                psum_gbf_w_addr = addr;
                out_data        = wr_data;
            end
            DONE:    su_add_finish = 1'b1;
            default: ;
        endcase
    end

    assign busy           = (state != IDLE);
    assign psum_rf_addr   = idx;
    assign psum_gbf_w_num = w_num_q;

    if (GW > COL*DW) begin : hi
        logic unused_hi;
        assign unused_hi = ^psum_gbf_r_data[GW-1:COL*DW];
    end

endmodule

// File: tb/tb_su_accum_writeback.sv
`timescale 1ns/1ps
// Directed bench for su_accum_writeback with ROW=COL=4, PSUM_DEPTH=2.
module tb_su_accum_writeback;

    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int DW  = 16;
    localparam int GW  = 64;
    localparam int AW  = 5;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [DW*ROW*COL-1:0]   psum_out;
    logic                    pe_psum_finish;
    logic                    conv_finish;
    logic [2:0]              red_mode;
    logic                    accum_en;
    logic                    sat_en;
    logic [AW-1:0]           base_addr;
    logic [GW-1:0]           psum_gbf_r_data;
    logic [0:0]              psum_rf_addr;
    logic [GW-1:0]           out_data;
    logic                    psum_gbf_w_en;
    logic [AW-1:0]           psum_gbf_w_addr;
    logic                    psum_gbf_w_num;
    logic                    psum_gbf_r_en;
    logic [AW-1:0]           psum_gbf_r_addr;
    logic                    su_add_finish;
    logic                    busy;

    always #5 clk = ~clk;

    su_accum_writeback #(
        .ROW(ROW), .COL(COL), .DATA_BITWIDTH(DW),
        .PSUM_RF_ADDR_BITWIDTH(1), .PSUM_DEPTH(2),
        .PSUM_GBF_DATA_BITWIDTH(GW), .PSUM_GBF_ADDR_BITWIDTH(AW),
        .PSUM_GBF_DEPTH(32)
    ) dut (
        .clk(clk), .reset(reset), .psum_out(psum_out),
        .pe_psum_finish(pe_psum_finish), .conv_finish(conv_finish),
        .red_mode(red_mode), .accum_en(accum_en), .sat_en(sat_en),
        .base_addr(base_addr), .psum_gbf_r_data(psum_gbf_r_data),
        .psum_rf_addr(psum_rf_addr), .out_data(out_data),
        .psum_gbf_w_en(psum_gbf_w_en), .psum_gbf_w_addr(psum_gbf_w_addr),
        .psum_gbf_w_num(psum_gbf_w_num), .psum_gbf_r_en(psum_gbf_r_en),
        .psum_gbf_r_addr(psum_gbf_r_addr), .su_add_finish(su_add_finish),
        .busy(busy)
    );

    logic [GW-1:0] mem [32];
    logic          preload_en;
    logic [GW-1:0] preload_word;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 32; i++) mem[i] <= preload_word;
        end else if (psum_gbf_w_en) begin
            mem[psum_gbf_w_addr] <= out_data;
        end
        if (psum_gbf_r_en) psum_gbf_r_data <= mem[psum_gbf_r_addr];
    end

    typedef struct {
        int mode;  int acc;  int sat;  int base;
        int kind;  int val;  int pre;
        int nwr;   int a0;   int a2;   int alast;
        int l0;    int llast; int lat;
    } vec_t;

    vec_t vt [9];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic setup(input vec_t v);
        red_mode  = 3'(v.mode);
        accum_en  = v.acc[0];
        sat_en    = v.sat[0];
        base_addr = AW'(v.base);
        for (int r = 0; r < ROW; r++) begin
            for (int c = 0; c < COL; c++) begin
                psum_out[(r*COL+c)*DW +: DW] =
                    (v.kind == 1) ? 16'(r) * 16'(v.val) : 16'(v.val);
            end
        end
        preload_word = {4{16'(v.pre)}};
        preload_en   = 1'b1;
        @(negedge clk);
        preload_en   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [AW-1:0] wa [$];
        logic [GW-1:0] wd [$];
        int            fin;
        int            viol;
        int            cyc;
        logic          pr;
        logic [AW-1:0] pa;
        setup(v);
        pe_psum_finish = 1'b1;
        @(negedge clk);
        pe_psum_finish = 1'b0;
        fin = -1; viol = 0; cyc = 1; pr = 1'b0; pa = '0;
        while (fin < 0 && cyc <= 60) begin
            if (pr && !(psum_gbf_w_en && psum_gbf_w_addr == pa)) viol++;
            if (psum_gbf_r_en && psum_gbf_w_en) viol++;
            pr = psum_gbf_r_en;
            pa = psum_gbf_r_addr;
            if (psum_gbf_w_en) begin
                wa.push_back(psum_gbf_w_addr);
                wd.push_back(out_data);
            end
            if (su_add_finish) begin
                fin = cyc;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check({nm, " finish latency"}, 64'(fin), 64'(v.lat));
        check({nm, " write count"}, 64'(wa.size()), 64'(v.nwr));
        check({nm, " rd/wr pairing"}, 64'(viol), 64'd0);
        if (wa.size() == v.nwr) begin
            check({nm, " first addr"}, 64'(wa[0]), 64'(v.a0));
            check({nm, " last addr"}, 64'(wa[v.nwr-1]), 64'(v.alast));
            check({nm, " first data"}, wd[0], {4{16'(v.l0)}});
            check({nm, " last data"}, wd[v.nwr-1], {4{16'(v.llast)}});
            if (v.nwr > 2) check({nm, " third addr"}, 64'(wa[2]), 64'(v.a2));
        end
        @(negedge clk);
        check({nm, " idle after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic w0;
        logic wexp;
        int   fin;
        int   bad;
        int   toggles;
        int   tcyc;
        int   nw_old;
        int   nw_new;
        int   found;
        int   nfin;
        logic prev;
        int   fins [$];

        vt[0] = '{2, 0, 0,  0, 0, 'h0003, 0,      2,  0,  0,  1, 'h000C, 'h000C,  7};
        vt[1] = '{0, 1, 0,  0, 1, 1,      5,      8,  0,  2,  7, 5,      8,      19};
        vt[2] = '{2, 0, 1,  0, 0, 'h4000, 0,      2,  0,  0,  1, 'h7FFF, 'h7FFF,  7};
        vt[3] = '{2, 0, 0,  0, 0, 'h4000, 0,      2,  0,  0,  1, 0,      0,       7};
        vt[4] = '{0, 0, 0, 30, 0, 3,      0,      8, 30,  0,  5, 3,      3,      19};
        vt[5] = '{1, 1, 0, 10, 1, 1,      5,      4, 10, 12, 13, 6,      10,     11};
        vt[6] = '{7, 0, 0,  3, 0, 'hFFFE, 0,      2,  3,  0,  4, 'hFFF8, 'hFFF8,  7};
        vt[7] = '{2, 0, 1,  0, 0, 'hC000, 0,      2,  0,  0,  1, 'h8000, 'h8000,  7};
        vt[8] = '{0, 1, 1,  0, 0, 'h0100, 'h7FF0, 8,  0,  2,  7, 'h7FFF, 'h7FFF, 19};

        reset = 1'b1; pe_psum_finish = 1'b0; conv_finish = 1'b0;
        red_mode = '0; accum_en = 1'b0; sat_en = 1'b0; base_addr = '0;
        psum_out = '0; preload_en = 1'b0; preload_word = '0;
        repeat (3) @(negedge clk);
        check("reset ctrl", {busy, psum_gbf_w_en, psum_gbf_r_en,
              su_add_finish, psum_gbf_w_num}, 64'd0);
        check("reset data", out_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle after reset", {busy, psum_gbf_w_en, psum_rf_addr}, 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("v%0d", i));

        // swap requested while idle
        w0 = psum_gbf_w_num;
        wexp = ~w0;
        conv_finish = 1'b1;
        @(negedge clk);
        conv_finish = 1'b0;
        check("idle swap", 64'(psum_gbf_w_num), 64'(wexp));

        // start and swap together: swap deferred to end of pass
        setup(vt[0]);
        w0 = psum_gbf_w_num;
        wexp = ~w0;
        pe_psum_finish = 1'b1;
        conv_finish = 1'b1;
        @(negedge clk);
        pe_psum_finish = 1'b0;
        conv_finish = 1'b0;
        fin = -1; bad = 0;
        for (int cyc = 1; cyc <= 20 && fin < 0; cyc++) begin
            if (psum_gbf_w_en && psum_gbf_w_num != w0) bad++;
            if (psum_gbf_w_num != w0) bad++;
            if (su_add_finish) fin = cyc;
            @(negedge clk);
        end
        check("both swap held", 64'(bad), 64'd0);
        check("both finish", 64'(fin), 64'd7);
        check("both swap after", 64'(psum_gbf_w_num), 64'(wexp));

        // queued start plus mid-pass swap
        setup(vt[0]);
        w0 = psum_gbf_w_num;
        prev = w0;
        toggles = 0; tcyc = -1; nw_old = 0; nw_new = 0;
        pe_psum_finish = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (su_add_finish) fins.push_back(cyc);
            if (psum_gbf_w_en) begin
                if (psum_gbf_w_num == w0) nw_old++;
                else nw_new++;
            end
            if (psum_gbf_w_num != prev) begin
                toggles++;
                tcyc = cyc;
            end
            prev = psum_gbf_w_num;
            pe_psum_finish = (cyc == 2 || cyc == 4);
            conv_finish    = (cyc == 3);
            @(negedge clk);
        end
        check("queue finish count", 64'(fins.size()), 64'd2);
        if (fins.size() == 2) begin
            check("queue finish 1", 64'(fins[0]), 64'd7);
            check("queue finish 2", 64'(fins[1]), 64'd15);
        end
        check("queue toggles", 64'(toggles), 64'd1);
        check("queue toggle cycle", 64'(tcyc), 64'd8);
        check("queue writes old buf", 64'(nw_old), 64'd2);
        check("queue writes new buf", 64'(nw_new), 64'd2);

        // reset during a write aborts the pass
        setup(vt[1]);
        pe_psum_finish = 1'b1;
        @(negedge clk);
        pe_psum_finish = 1'b0;
        found = 0;
        for (int cyc = 1; cyc <= 10 && found == 0; cyc++) begin
            if (psum_gbf_w_en) found = 1;
            else @(negedge clk);
        end
        check("reset reached WR", 64'(found), 64'd1);
        check("w_num before reset", 64'(psum_gbf_w_num), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midpass reset ctrl", {busy, psum_gbf_w_en, psum_gbf_r_en,
              su_add_finish, psum_gbf_w_num, psum_rf_addr,
              psum_gbf_w_addr, psum_gbf_r_addr}, 64'd0);
        check("midpass reset data", out_data, 64'd0);
        reset = 1'b0;
        nfin = 0;
        repeat (25) begin
            @(negedge clk);
            if (su_add_finish || busy) nfin++;
        end
        check("no finish after abort", 64'(nfin), 64'd0);
        run_vec(vt[0], "post reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/su_accum_writeback.md
# su_accum_writeback

Parametrised successor to the column-sum spatial adder that sits between the PE array and the psum GBF. On each `pe_psum_finish` it walks every PSUM RF address. For each address it reduces the ROW×COL psums down the rows in run-time-selectable groups, optionally accumulates each result with the value already stored in the psum GBF, and writes it back. It adds configurable reduction grouping, a GBF base address with wrap-around, overwrite/accumulate mode, optional saturation and a queued start.

## Interface
Parameters:
- `ROW`, 16, PE array rows; power of two, 2..128.
- `COL`, 16, PE array columns.
- `DATA_BITWIDTH`, 16, signed psum width.
- `PSUM_RF_ADDR_BITWIDTH`, 2, PSUM RF address width.
- `PSUM_DEPTH`, 4, PSUM RF entries walked per pass.
- `PSUM_GBF_DATA_BITWIDTH`, 512, psum GBF word width; must be ≥ COL*DATA_BITWIDTH.
- `PSUM_GBF_ADDR_BITWIDTH`, 5, psum GBF address width.
- `PSUM_GBF_DEPTH`, 32, psum GBF depth (= 2^PSUM_GBF_ADDR_BITWIDTH).

Ports:
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-high.
- `psum_out` input DATA_BITWIDTH*ROW*COL: element (r,c) at bits [(r*COL+c)*DW +: DW]. Combinationally valid for the current `psum_rf_addr`.
- `pe_psum_finish` input 1: single-cycle pulse that starts a pass.
- `conv_finish` input 1: pulse requesting a ping-pong buffer swap.
- `red_mode` input 3: group size is 2^red_mode rows; values > log2(ROW) act as log2(ROW).
- `accum_en` input 1: 1 = read-modify-write, 0 = overwrite.
- `sat_en` input 1: 1 = saturate, 0 = wrap.
- `base_addr` input PSUM_GBF_ADDR_BITWIDTH: first GBF address of the pass.
- `psum_gbf_r_data` input PSUM_GBF_DATA_BITWIDTH: GBF read data, valid one cycle after `r_en`.
- `psum_rf_addr` output PSUM_RF_ADDR_BITWIDTH: RF entry being processed.
- `out_data` output PSUM_GBF_DATA_BITWIDTH: write data; lane c at [c*DW +: DW], upper bits 0.
- `psum_gbf_w_en` output 1: GBF write enable.
- `psum_gbf_w_addr` output PSUM_GBF_ADDR_BITWIDTH: GBF write address.
- `psum_gbf_w_num` output 1: active GBF buffer, 0 = buf1, 1 = buf2.
- `psum_gbf_r_en` output 1: GBF read enable.
- `psum_gbf_r_addr` output PSUM_GBF_ADDR_BITWIDTH: GBF read address.
- `su_add_finish` output 1: one-cycle pulse at the end of a pass.
- `busy` output 1: pass in progress.

## Operation
- FSM states: IDLE, FETCH, RD, WR, DONE.
- IDLE → FETCH on `pe_psum_finish` or on a pending start.
  - On entry, `red_mode`, `accum_en`, `sat_en` and `base_addr` are latched; changes mid-pass are ignored.
  - Group count G = ROW >> m, where m = min(red_mode, log2(ROW)).
- FETCH:
  - Drive `psum_rf_addr` = idx, starting at 0.
  - At the end of the cycle, register all G×COL group sums.
  - gsum[g][c] = signed sum of psum_out(r,c) for r in [g*2^m, (g+1)*2^m), held in DW+log2(ROW) bits.
  - g := 0, then → RD.
- RD:
  - Drive `psum_gbf_r_en` = accum_en and `psum_gbf_r_addr` = A, where A = (base + idx*G + g) mod PSUM_GBF_DEPTH.
  - → WR.
- WR:
  - Drive `psum_gbf_w_en` = 1 and `psum_gbf_w_addr` = A.
  - Lane c = f(gsum[g][c] + (accum_en ? r_data lane c : 0)), with the sum computed in DW+log2(ROW)+1 bits.
  - f saturates to [-2^(DW-1), 2^(DW-1)-1] when sat_en = 1; otherwise it keeps the low DW bits.
  - If g < G-1: g++, → RD.
  - Else if idx < PSUM_DEPTH-1: idx++, → FETCH.
  - Else → DONE.
- DONE:
  - Pulse `su_add_finish` for one cycle.
  - Apply any pending swap.
  - → IDLE.
- Start queue: a `pe_psum_finish` arriving while busy (FETCH..DONE) sets a one-deep pending flag; further pulses are dropped. A pending start begins the cycle after DONE.
- Swap: `conv_finish` in IDLE toggles `psum_gbf_w_num` on the next edge. While busy it sets a pending-swap flag, applied in DONE, so writes within a pass never split across buffers.
- Start and `conv_finish` together in IDLE: the start is taken and the swap is deferred to the end of that pass.
- Address wrap: A is computed modulo PSUM_GBF_DEPTH with no error flag.

## Timing
- Reset value of every output is 0, including `psum_gbf_w_num`. The FSM goes to IDLE and both pending flags are cleared.
  - Reset mid-pass aborts the pass; no `su_add_finish` is issued.
- Start latency: FETCH is the cycle after the `pe_psum_finish` edge.
- Pass length is PSUM_DEPTH*(1+2G) cycles from FETCH through the last WR. `su_add_finish` follows one cycle later.
- `busy` is 1 from FETCH through DONE.
- The read/write pair for one address is exactly RD then WR. RD and WR are never asserted in the same cycle.
- Timing is identical for `accum_en` = 0 and 1.

## Test plan
- ROW=COL=4, PSUM_DEPTH=2, m=2, accum_en=0, base=0, all psums 3 → exactly 2 writes, addresses 0 and 1, lanes 12. `su_add_finish` arrives 7 cycles after the start pulse.
- m=0, accum_en=1, GBF preloaded with 5, psum(r,c)=r → 8 writes at addresses 0..7; lane = r+5 per group; each RD is followed by WR to the same address.
- sat_en=1, DW=16, psum 0x4000 in every row, m=2 → lanes 0x7FFF. Repeat with sat_en=0 → lanes 0x0000 (wrapped).
- base=30, G=4, PSUM_DEPTH=1 → write addresses 30, 31, 0, 1.
- `pe_psum_finish` pulsed twice mid-pass, plus `conv_finish` mid-pass → exactly one queued pass starts the cycle after DONE. `w_num` toggles once, in DONE, and never changes during writes.
- Reset asserted during WR → next cycle all outputs are 0, no `su_add_finish`, and a new start behaves normally.
